uart_rx_8n1: RTL and testbench



---
 rtl/uart_rx_8n1.sv | 137 +++++++++++++
 tb/tb_uart_rx_8n1.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_8n1.sv
// UART 8N1 receiver: 2-FF synchronized line, per-bit divider, 3-sample
// majority vote mid-bit, one-cycle valid / framing-error strobes.
module uart_rx_8n1 #(
  parameter int unsigned CLK_FREQ = 12_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int unsigned DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned CW  = $clog2(DIV);

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] SMP0     = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] SMP1     = CW'(DIV / 2);
  localparam logic [CW-1:0] DECIDE   = CW'(DIV / 2 + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_e;

  state_e        state_q, state_d;
  logic          rx_meta_q, rx_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          smp0_q, smp0_d;
  logic          smp1_q, smp1_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          vote;
  logic          decide;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      smp0_q    <= 1'b1;
      smp1_q    <= 1'b1;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      smp0_q    <= smp0_d;
      smp1_q    <= smp1_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign vote   = (smp0_q & smp1_q) | (smp0_q & rx_s_q) | (smp1_q & rx_s_q);
  assign decide = (cnt_q == DECIDE);

  // cnt is zeroed only while idle; it free-runs modulo DIV through DATA and
  // STOP so every decision point lands exactly DIV cycles after the previous.
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    smp0_d    = (cnt_q == SMP0) ? rx_s_q : smp0_q;
    smp1_d    = (cnt_q == SMP1) ? rx_s_q : smp1_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (decide) begin
          if (vote) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (decide) begin
          shift_d   = {vote, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (decide) begin
          if (vote) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_busy      = (state_q != IDLE);
    rx_data      = data_q;
    rx_valid     = valid_q;
    rx_frame_err = ferr_q;
  end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed self-checking bench for uart_rx_8n1 at default parameters (DIV=104).
module tb_uart_rx_8n1;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  int unsigned valid_cnt = 0;
  int unsigned err_cnt   = 0;
  int unsigned both_cnt  = 0;
  logic [7:0]  got[$];

  uart_rx_8n1 #(.CLK_FREQ(12_000_000), .BAUD(115200)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      got.push_back(rx_data);
    end
    if (rx_frame_err) err_cnt++;
    if (rx_valid && rx_frame_err) both_cnt++;
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned per);
    rx = 1'b0;
    idle(per);
    for (int unsigned i = 0; i < 8; i++) begin
      rx = b[i];
      idle(per);
    end
    rx = 1'b1;
    idle(per);
  endtask

  task automatic test_reset;
    idle(3);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
    checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", rx_frame_err); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    rst_n = 1'b1;
    idle(10);
  endtask

  task automatic test_basic;
    int unsigned v0, e0, q0;
    v0 = valid_cnt; e0 = err_cnt; q0 = got.size();
    send_byte(8'h55, 104);
    idle(20);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL basic_valid_count got=%0d exp=1", valid_cnt - v0); end
    checks++; if (got.size() > q0 && got[q0] !== 8'h55) begin errors++; $display("FAIL basic_data got=%h exp=55", got[q0]); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL basic_ferr got=%0d exp=0", err_cnt - e0); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got=%b exp=0", rx_busy); end
    checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL basic_hold got=%h exp=55", rx_data); end
  endtask

  task automatic test_glitch;
    int unsigned v0, e0, q0, busy_cycles;
    v0 = valid_cnt; e0 = err_cnt;
    busy_cycles = 0;
    rx = 1'b0;
    for (int unsigned i = 0; i < 150; i++) begin
      if (i == 30) rx = 1'b1;
      @(negedge clk);
      if (rx_busy) busy_cycles++;
    end
    checks++; if (busy_cycles < 53 || busy_cycles > 55) begin errors++; $display("FAIL glitch_busy_len got=%0d exp=54", busy_cycles); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL glitch_valid got=%0d exp=0", valid_cnt - v0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL glitch_ferr got=%0d exp=0", err_cnt - e0); end
    q0 = got.size();
    send_byte(8'hA5, 104);
    idle(20);
    checks++; if (got.size() != q0 + 1 || got[q0] !== 8'hA5) begin errors++; $display("FAIL glitch_next_byte count=%0d data=%h exp=1 A5", got.size() - q0, rx_data); end
  endtask

  task automatic test_back_to_back;
    int unsigned e0, q0;
    e0 = err_cnt; q0 = got.size();
    send_byte(8'hA5, 104);
    send_byte(8'h3C, 104);
    idle(20);
    checks++; if (got.size() != q0 + 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", got.size() - q0); end
    checks++; if (got.size() > q0 && got[q0] !== 8'hA5) begin errors++; $display("FAIL b2b_first got=%h exp=A5", got[q0]); end
    checks++; if (got.size() > q0 + 1 && got[q0+1] !== 8'h3C) begin errors++; $display("FAIL b2b_second got=%h exp=3C", got[q0+1]); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL b2b_ferr got=%0d exp=0", err_cnt - e0); end
  endtask

  task automatic test_break;
    int unsigned v0, e0, q0;
    v0 = valid_cnt; e0 = err_cnt;
    rx = 1'b0;
    idle(20 * 104);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL break_ferr_count got=%0d exp=1", err_cnt - e0); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL break_valid got=%0d exp=0", valid_cnt - v0); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL break_data_hold got=%h exp=3C", rx_data); end
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL break_busy_low got=%b exp=1", rx_busy); end
    rx = 1'b1;
    idle(50);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL break_busy_release got=%b exp=0", rx_busy); end
    q0 = got.size();
    send_byte(8'h0F, 104);
    idle(20);
    checks++; if (got.size() != q0 + 1 || got[q0] !== 8'h0F) begin errors++; $display("FAIL break_next_byte count=%0d data=%h exp=1 0F", got.size() - q0, rx_data); end
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL break_total_ferr got=%0d exp=1", err_cnt - e0); end
  endtask

  task automatic test_skew;
    int unsigned e0, q0;
    logic [7:0] exp_b [4];
    int unsigned per [4];
    exp_b[0] = 8'h81; per[0] = 101;
    exp_b[1] = 8'hFE; per[1] = 101;
    exp_b[2] = 8'h81; per[2] = 107;
    exp_b[3] = 8'hFE; per[3] = 107;
    e0 = err_cnt; q0 = got.size();
    for (int unsigned i = 0; i < 4; i++) send_byte(exp_b[i], per[i]);
    idle(20);
    checks++; if (got.size() != q0 + 4) begin errors++; $display("FAIL skew_count got=%0d exp=4", got.size() - q0); end
    for (int unsigned i = 0; i < 4; i++) begin
      checks++;
      if (got.size() > q0 + i && got[q0+i] !== exp_b[i]) begin
        errors++; $display("FAIL skew_byte%0d period=%0d got=%h exp=%h", i, per[i], got[q0+i], exp_b[i]);
      end
    end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL skew_ferr got=%0d exp=0", err_cnt - e0); end
  endtask

  task automatic test_reset_midframe;
    int unsigned v0, q0;
    logic [7:0] b;
    b = 8'hC3;
    rx = 1'b0;
    idle(104);
    for (int unsigned i = 0; i < 4; i++) begin
      rx = b[i];
      idle(104);
    end
    rx = b[4];
    idle(50);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL midframe_busy_before got=%b exp=1", rx_busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL midframe_busy got=%b exp=0", rx_busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midframe_data got=%h exp=00", rx_data); end
    checks++; if (rx_valid !== 1'b0 || rx_frame_err !== 1'b0) begin errors++; $display("FAIL midframe_strobes got=%b%b exp=00", rx_valid, rx_frame_err); end
    idle(5);
    rx = 1'b1;
    idle(5);
    rst_n = 1'b1;
    idle(200);
    v0 = valid_cnt; q0 = got.size();
    send_byte(8'h5A, 104);
    idle(20);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL midframe_valid_count got=%0d exp=1", valid_cnt - v0); end
    checks++; if (got.size() > q0 && got[q0] !== 8'h5A) begin errors++; $display("FAIL midframe_next_byte got=%h exp=5A", got[q0]); end
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL strobe_overlap got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    test_reset();
    test_basic();
    test_glitch();
    test_back_to_back();
    test_break();
    test_skew();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
